// File: rtl/fec_encode_scheduler.sv
// Schedules jobs from two requesters onto one shared rate-1/2 convolutional encoder.
// Each job: round-robin grant, encoder clear, serial feed with flush bit, wait for done, hold codeword until accepted.
module fec_encode_scheduler #(
    parameter int TIMEOUT   = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clck,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [47:0] frame0,
    input  logic [47:0] frame1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        enc_start,
    output logic        enc_data,
    input  logic        enc_status,
    input  logic [95:0] enc_fec,
    output logic [95:0] fec_out,
    output logic        fec_src,
    output logic        fec_valid,
    input  logic        fec_ready,
    output logic        busy,
    output logic        err,
    output logic [2:0]  fsm_state
);

    // Output handshake: fec_out/fec_src are valid while fec_valid is high and
    // must stay stable until a clock edge sees fec_valid && fec_ready.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state, state_d;
    logic [47:0]   frame_q, frame_d;
    logic          job_src, job_src_d;
    logic          rr, rr_d;
    logic [5:0]    bit_idx, bit_idx_d;
    logic [5:0]    idx_next;
    logic [WW-1:0] wait_cnt, wait_cnt_d;
    logic          gnt0_d, gnt1_d;
    logic          enc_start_d, enc_data_d;
    logic [95:0]   fec_out_d;
    logic          fec_src_d, fec_valid_d;
    logic          busy_d, err_d;
    logic          pick1;

    function automatic logic frame_bit(input logic [47:0] f, input logic [5:0] i);
        logic [5:0]  j;
        logic [47:0] s;
        j = MSB_FIRST ? (6'd47 - i) : i;
        s = f >> j;
        return s[0];
    endfunction

    assign fsm_state = state;

    always_comb begin
        state_d     = state;
        frame_d     = frame_q;
        job_src_d   = job_src;
        rr_d        = rr;
        bit_idx_d   = bit_idx;
        wait_cnt_d  = wait_cnt;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        enc_start_d = 1'b0;
        enc_data_d  = 1'b0;
        fec_out_d   = fec_out;
        fec_src_d   = fec_src;
        fec_valid_d = fec_valid;
        err_d       = err;
        idx_next    = bit_idx + 6'd1;
        pick1       = req1 && (!req0 || rr);

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    frame_d     = pick1 ? frame1 : frame0;
                    job_src_d   = pick1;
                    gnt0_d      = !pick1;
                    gnt1_d      = pick1;
                    rr_d        = !pick1;
                    enc_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                bit_idx_d  = 6'd0;
                enc_data_d = frame_bit(frame_q, 6'd0);
                state_d    = FEED;
            end
            FEED: begin
                // Index 48 is the flush cycle: a zero bit with no frame data.
                if (bit_idx == 6'd48) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end else begin
                    bit_idx_d  = idx_next;
                    enc_data_d = (idx_next < 6'd48) ? frame_bit(frame_q, idx_next) : 1'b0;
                end
            end
            WAIT: begin
                if (enc_status) begin
                    fec_out_d   = enc_fec;
                    fec_src_d   = job_src;
                    fec_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (wait_cnt + WW'(1) == WW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + WW'(1);
                end
            end
            OUT: begin
                if (fec_ready) begin
                    fec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_q   <= '0;
            job_src   <= 1'b0;
            rr        <= 1'b0;
            bit_idx   <= '0;
            wait_cnt  <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            enc_start <= 1'b0;
            enc_data  <= 1'b0;
            fec_out   <= '0;
            fec_src   <= 1'b0;
            fec_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            frame_q   <= frame_d;
            job_src   <= job_src_d;
            rr        <= rr_d;
            bit_idx   <= bit_idx_d;
            wait_cnt  <= wait_cnt_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            enc_start <= enc_start_d;
            enc_data  <= enc_data_d;
            fec_out   <= fec_out_d;
            fec_src   <= fec_src_d;
            fec_valid <= fec_valid_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_fec_encode_scheduler.sv
// Randomized scoreboard bench for fec_encode_scheduler with a behavioural encoder stub
// (K=4 rate-1/2 code, generators 1011/1111) and a frame-level reference codeword model.
module tb_fec_encode_scheduler;

    logic        clck = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [47:0] frame0, frame1;
    logic        gnt0, gnt1;
    logic        enc_start, enc_data;
    logic        enc_status;
    logic [95:0] enc_fec;
    logic [95:0] fec_out;
    logic        fec_src, fec_valid;
    logic        fec_ready;
    logic        busy, err;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [96:0] exp_q[$];
    bit          grant_log[$];
    int          outstanding = 0;
    bit          rr_m = 1'b0;
    bit          expect_output = 1'b1;
    bit          stub_on = 1'b1;

    fec_encode_scheduler dut (
        .clck(clck), .rst_n(rst_n), .req0(req0), .req1(req1),
        .frame0(frame0), .frame1(frame1), .gnt0(gnt0), .gnt1(gnt1),
        .enc_start(enc_start), .enc_data(enc_data), .enc_status(enc_status),
        .enc_fec(enc_fec), .fec_out(fec_out), .fec_src(fec_src),
        .fec_valid(fec_valid), .fec_ready(fec_ready), .busy(busy), .err(err),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clck = ~clck;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Codeword of a whole frame: bit k fed is frame[47-k]; pair k lands at [95-2k:94-2k].
    function automatic logic [95:0] ref_code(input logic [47:0] f);
        logic [95:0] c;
        bit          xs[48];
        bit          x1, x2, x3;
        for (int k = 0; k < 48; k++) xs[k] = f[47-k];
        for (int k = 0; k < 48; k++) begin
            x1 = (k >= 1) ? xs[k-1] : 1'b0;
            x2 = (k >= 2) ? xs[k-2] : 1'b0;
            x3 = (k >= 3) ? xs[k-3] : 1'b0;
            c[95-2*k] = xs[k] ^ x2 ^ x3;
            c[94-2*k] = xs[k] ^ x1 ^ x2 ^ x3;
        end
        return c;
    endfunction

    // ---------------- encoder stub ----------------
    logic [2:0]  stub_sr;
    logic [95:0] stub_code;
    int          stub_cnt;

    always @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            stub_sr    <= '0;
            stub_code  <= '0;
            stub_cnt   <= 60;
            enc_status <= 1'b0;
            enc_fec    <= '0;
        end else if (enc_start) begin
            stub_sr    <= '0;
            stub_code  <= '0;
            stub_cnt   <= 0;
            enc_status <= 1'b0;
        end else begin
            enc_status <= 1'b0;
            if (stub_cnt < 48) begin
                stub_code <= {stub_code[93:0],
                              enc_data ^ stub_sr[1] ^ stub_sr[2],
                              enc_data ^ stub_sr[0] ^ stub_sr[1] ^ stub_sr[2]};
                stub_sr   <= {stub_sr[1:0], enc_data};
                stub_cnt  <= stub_cnt + 1;
            end else if (stub_cnt == 48) begin
                stub_cnt <= stub_cnt + 1;
            end else if (stub_cnt == 49) begin
                stub_cnt <= stub_cnt + 1;
                if (stub_on) begin
                    enc_status <= 1'b1;
                    enc_fec    <= stub_code;
                end
            end
        end
    end

    // ---------------- grant checker / expected-queue producer ----------------
    bit          prev_r0 = 1'b0, prev_r1 = 1'b0;
    logic [47:0] prev_f0 = '0, prev_f1 = '0;

    always @(negedge clck) begin
        bit pick;
        if (rst_n && (gnt0 || gnt1)) begin
            check(prev_r0 || prev_r1, "grant_without_req", {gnt1, gnt0}, 0);
            pick = prev_r1 && (!prev_r0 || rr_m);
            check(gnt1 == pick && gnt0 == !pick, "grant_rr", {gnt1, gnt0}, {pick, !pick});
            check(outstanding == 0, "one_in_flight", outstanding, 0);
            if (expect_output) begin
                exp_q.push_back({pick, ref_code(pick ? prev_f1 : prev_f0)});
                outstanding++;
            end
            rr_m = !pick;
            grant_log.push_back(pick);
        end
        prev_r0 = req0;
        prev_r1 = req1;
        prev_f0 = frame0;
        prev_f1 = frame1;
    end

    // ---------------- output monitor ----------------
    bit          prev_stall = 1'b0;
    logic [95:0] prev_out;
    bit          prev_src;

    always @(negedge clck) begin
        logic [96:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (fec_valid) begin
            if (prev_stall) begin
                check(fec_out === prev_out, "stall_out_stable", fec_out, prev_out);
                check(fec_src === prev_src, "stall_src_stable", fec_src, prev_src);
            end
            if (fec_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", fec_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(fec_out === e[95:0], "fec_out", fec_out, e[95:0]);
                    check(fec_src === e[96], "fec_src", fec_src, e[96]);
                    outstanding--;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_out   = fec_out;
                prev_src   = fec_src;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clck);
            if (gnt0 || gnt1) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "grant_wait", got, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clck);
            if (!busy && !fec_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(done, "idle_wait", busy, 0);
    endtask

    task automatic run_single(input bit which, input logic [47:0] f, output logic [95:0] cap);
        bit got;
        int n;
        cap = '0;
        @(posedge clck); #1;
        if (which) begin frame1 = f; req1 = 1'b1; end
        else       begin frame0 = f; req0 = 1'b1; end
        wait_gnt(got);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) return;
        n = 1;
        while (!fec_valid && n < 200) begin
            @(negedge clck);
            n++;
        end
        check(n == 53, "latency", n, 53);
        cap = fec_out;
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({gnt0, gnt1, enc_start, enc_data, fec_valid, fec_src, busy, err} === 8'h00,
              {tag, "_ctrl"}, {gnt0, gnt1, enc_start, enc_data, fec_valid, fec_src, busy, err}, 0);
        check(fec_out === 96'h0, {tag, "_fec_out"}, fec_out, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [95:0] cap;
        logic [47:0] f;
        bit          got, saw_valid;
        int          n, cnt;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        frame0 = '0; frame1 = '0; fec_ready = 1'b1;
        repeat (3) @(negedge clck);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clck);

        // all-zero frame from requester 0
        run_single(1'b0, 48'h0, cap);
        check(cap === 96'h0, "zero_frame", cap, 0);
        check(err === 1'b0, "err_clear", err, 0);

        // single leading one gives the encoder impulse response
        run_single(1'b1, 48'h8000_0000_0000, cap);
        check(cap === 96'hDF00_0000_0000_0000_0000_0000, "impulse", cap, 96'hDF00_0000_0000_0000_0000_0000);

        // random single jobs
        for (int j = 0; j < 6; j++) begin
            f = {$urandom, $urandom};
            run_single(1'($urandom_range(0, 1)), f, cap);
        end

        // both requesters held high for four jobs
        grant_log.delete();
        @(posedge clck); #1;
        frame0 = {$urandom, $urandom};
        frame1 = {$urandom, $urandom};
        req0 = 1'b1; req1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400 && cnt < 4; i++) begin
            @(negedge clck);
            if (gnt0 || gnt1) cnt++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check(cnt == 4, "four_grants", cnt, 4);
        wait_idle();
        for (int i = 1; i < 4 && i < grant_log.size(); i++)
            check(grant_log[i] != grant_log[i-1], "alternate", grant_log[i], !grant_log[i-1]);

        // back-pressure in OUT with a pending request
        @(posedge clck); #1;
        fec_ready = 1'b0;
        frame0 = {$urandom, $urandom};
        req0 = 1'b1;
        wait_gnt(got);
        req0 = 1'b0;
        frame1 = {$urandom, $urandom};
        req1 = 1'b1;
        n = 0;
        while (!fec_valid && n < 200) begin
            @(negedge clck);
            n++;
        end
        check(fec_valid === 1'b1, "stall_valid_seen", fec_valid, 1);
        cap = fec_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clck);
            check(fec_valid === 1'b1 && fec_out === cap, "stall_hold", fec_out, cap);
            check(gnt1 === 1'b0, "stall_no_grant", gnt1, 0);
        end
        @(posedge clck); #1;
        fec_ready = 1'b1;
        @(negedge clck);
        @(negedge clck);
        check(fec_valid === 1'b0 && gnt1 === 1'b0 && busy === 1'b0, "accept_then_idle",
              {fec_valid, gnt1, busy}, 0);
        @(negedge clck);
        check(gnt1 === 1'b1, "pending_grant", gnt1, 1);
        req1 = 1'b0;
        wait_idle();

        // encoder never reports done
        stub_on = 1'b0;
        expect_output = 1'b0;
        @(posedge clck); #1;
        frame0 = {$urandom, $urandom};
        req0 = 1'b1;
        wait_gnt(got);
        req0 = 1'b0;
        cnt = 1;
        saw_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clck);
            saw_valid |= fec_valid;
            if (!busy) break;
            cnt++;
        end
        check(cnt == 58, "timeout_busy_cycles", cnt, 58);
        check(err === 1'b1, "timeout_err", err, 1);
        check(saw_valid == 1'b0, "timeout_no_valid", saw_valid, 0);
        stub_on = 1'b1;
        expect_output = 1'b1;
        run_single(1'b1, {$urandom, $urandom}, cap);
        check(err === 1'b1, "err_sticky", err, 1);

        // reset in the middle of FEED (bit index 20)
        @(posedge clck); #1;
        frame0 = {$urandom, $urandom};
        req0 = 1'b1;
        wait_gnt(got);
        req0 = 1'b0;
        repeat (21) @(negedge clck);
        check(fsm_state === 3'd2, "in_feed_before_reset", fsm_state, 2);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        outstanding = 0;
        rr_m = 1'b0;
        check_reset_outputs("midjob_reset");
        repeat (3) @(negedge clck);
        rst_n = 1'b1;
        repeat (2) @(negedge clck);
        run_single(1'b0, {$urandom, $urandom}, cap);
        check(err === 1'b0, "err_after_reset", err, 0);

        repeat (5) @(negedge clck);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
